// File: rtl/qeciphy_pkg.sv
// Shared types and helpers for the QECIPHY RX alignment supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: one-hot state enum for the RX align controller, the FAW
// pattern and its detector (is_faw), and a counter-width helper.
package qeciphy_pkg;

  typedef enum logic [5:0] {
    ST_IDLE       = 6'b000001,
    ST_HOLD       = 6'b000010,
    ST_WAIT_ALIGN = 6'b000100,
    ST_LOCKED     = 6'b001000,
    ST_RETRY      = 6'b010000,
    ST_FAILED     = 6'b100000
  } qeciphy_rx_align_ctrl_fsm_t;

  // Frame alignment word inserted periodically by the far-end TX.
  localparam logic [63:0] FAW_WORD = 64'hA5C3_0F96_5A3C_F069;

  localparam int RETRY_CNT_W = 4;

  function automatic logic is_faw(input logic [63:0] word);
    return word == FAW_WORD;
  endfunction

  // $clog2 of a count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qeciphy_rx_align_ctrl_if.sv
// Bundles the aligner-facing and status signals of the RX align controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or free-running data.
//
// Ports: enable_i, aligned_i, tdata_64b_i flow into the controller;
// dp_rst_n_o, rx_locked_o, rx_error_o, retry_count_o, realign_count_o
// flow out. master = driving side (PHY top/aligner), slave = controller.
interface qeciphy_rx_align_ctrl_if;
  logic        enable_i;
  logic        aligned_i;
  logic [63:0] tdata_64b_i;
  logic        dp_rst_n_o;
  logic        rx_locked_o;
  logic        rx_error_o;
  logic [3:0]  retry_count_o;
  logic [15:0] realign_count_o;

  modport master (
    output enable_i, aligned_i, tdata_64b_i,
    input  dp_rst_n_o, rx_locked_o, rx_error_o, retry_count_o, realign_count_o
  );

  modport slave (
    input  enable_i, aligned_i, tdata_64b_i,
    output dp_rst_n_o, rx_locked_o, rx_error_o, retry_count_o, realign_count_o
  );
endinterface

// File: rtl/qeciphy_rx_faw_monitor.sv
// Tracks FAW periodicity while locked and flags loss of alignment.
// Latency: loss is combinational from the gap/miss counters and faw_hit.
// Backpressure: none; counts every cycle while en is high.
//
// Ports: clk, rst_n (async active-low), en (high only in LOCKED; low
// clears both counters so LOCKED entry starts from zero), faw_hit
// (registered FAW detect), loss (MISS_THRESHOLD consecutive empty periods).
module qeciphy_rx_faw_monitor
  import qeciphy_pkg::*;
#(
  parameter int FAW_PERIOD     = 64,
  parameter int MISS_THRESHOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic faw_hit,
  output logic loss
);

  localparam int GAP_W  = cnt_width(FAW_PERIOD);
  localparam int MISS_W = cnt_width(MISS_THRESHOLD);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FAW_PERIOD - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_THRESHOLD - 1);

  logic [GAP_W-1:0]  gap_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              period_end;

  assign period_end = (gap_cnt == GAP_LAST);

  // The miss that would bring the count up to the threshold is flagged
  // directly, so the miss counter never has to hold the threshold itself.
  // A hit landing on the last gap cycle still counts as a hit.
  assign loss = en && !faw_hit && period_end && (miss_cnt == MISS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt  <= '0;
      miss_cnt <= '0;
    end else if (!en || faw_hit) begin
      gap_cnt  <= '0;
      miss_cnt <= '0;
    end else if (period_end) begin
      gap_cnt  <= '0;
      miss_cnt <= loss ? '0 : miss_cnt + 1'b1;
    end else begin
      gap_cnt  <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qeciphy_rx_align_ctrl.sv
// RX 32b->64b aligner supervisor: reset sequencing, lock wait, FAW-based
// loss detection, bounded realignment retries.
// Latency: enable/aligned/loss act on the next clk_i edge; FAW detect adds 1.
// Backpressure: none; outputs are status levels.
//
// Ports: clk_i, rst_n_i (async active-low), bus (slave modport of
// qeciphy_rx_align_ctrl_if). Optional macro QECIPHY_RX_ALIGN_STATS_EN
// builds the saturating realign_count_o counter; without it the port is 0.
module qeciphy_rx_align_ctrl
  import qeciphy_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int FAW_PERIOD      = 64,
  parameter int MISS_THRESHOLD  = 4,
  parameter int MAX_RETRIES     = 7
) (
  input logic                    clk_i,
  input logic                    rst_n_i,
  qeciphy_rx_align_ctrl_if.slave bus
);

  localparam int HOLD_W = cnt_width(RST_HOLD_CYCLES);
  localparam int WAIT_W = cnt_width(LOCK_TIMEOUT);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_LIM = RETRY_CNT_W'(MAX_RETRIES);

  qeciphy_rx_align_ctrl_fsm_t state, state_next;

  logic [HOLD_W-1:0]      hold_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [RETRY_CNT_W-1:0] retry_cnt;
  logic [RETRY_CNT_W-1:0] retry_inc;
  logic                   faw_hit;
  logic                   loss;
  logic                   dp_rst_n_d;
  logic                   dp_rst_n_q;

  assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      faw_hit <= 1'b0;
    end else begin
      faw_hit <= is_faw(bus.tdata_64b_i) && bus.aligned_i;
    end
  end

  qeciphy_rx_faw_monitor #(
    .FAW_PERIOD     (FAW_PERIOD),
    .MISS_THRESHOLD (MISS_THRESHOLD)
  ) u_faw_monitor (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .en      (state == ST_LOCKED),
    .faw_hit (faw_hit),
    .loss    (loss)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!bus.enable_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       state_next = ST_HOLD;
        ST_HOLD:       if (hold_cnt == HOLD_LAST) state_next = ST_WAIT_ALIGN;
        ST_WAIT_ALIGN: begin
          if (bus.aligned_i)              state_next = ST_LOCKED;
          else if (wait_cnt == WAIT_LAST) state_next = ST_RETRY;
        end
        // Aligner dropping lock and FAW loss both lead to RETRY; the
        // aligned_i check needs no FAW history so it acts at once.
        ST_LOCKED:     if (!bus.aligned_i || loss) state_next = ST_RETRY;
        ST_RETRY:      state_next = (retry_inc >= RETRY_LIM) ? ST_FAILED : ST_HOLD;
        ST_FAILED:     state_next = ST_FAILED;
        default:       state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath reset is released only while waiting for or holding lock; it is
  // registered from the next state so it toggles with the state change.
  assign dp_rst_n_d = (state_next == ST_WAIT_ALIGN) || (state_next == ST_LOCKED);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dp_rst_n_q <= 1'b0;
      hold_cnt   <= '0;
      wait_cnt   <= '0;
      retry_cnt  <= '0;
    end else begin
      dp_rst_n_q <= dp_rst_n_d;
      hold_cnt   <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
      wait_cnt   <= (state == ST_WAIT_ALIGN) ? wait_cnt + 1'b1 : '0;
      if (state_next == ST_IDLE) begin
        retry_cnt <= '0;
      end else if (state == ST_RETRY) begin
        retry_cnt <= retry_inc;
      end
    end
  end

  assign bus.dp_rst_n_o    = dp_rst_n_q;
  assign bus.rx_locked_o   = (state == ST_LOCKED);
  assign bus.rx_error_o    = (state == ST_FAILED);
  assign bus.retry_count_o = retry_cnt;

`ifdef QECIPHY_RX_ALIGN_STATS_EN
  logic [15:0] realign_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      realign_cnt <= '0;
    end else if ((state == ST_LOCKED) && (state_next == ST_RETRY) && (realign_cnt != '1)) begin
      realign_cnt <= realign_cnt + 1'b1;
    end
  end

  assign bus.realign_count_o = realign_cnt;
`else
  assign bus.realign_count_o = '0;
`endif

endmodule

// File: tb/tb_qeciphy_rx_align_ctrl.sv
// Testbench for qeciphy_rx_align_ctrl: stimulus pushes the expected output
// change (cycle stamp + output values) into a queue; a monitor pops one entry
// on every observed output change and compares.
module tb_qeciphy_rx_align_ctrl;
  import qeciphy_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qeciphy_rx_align_ctrl_if bus();

  qeciphy_rx_align_ctrl #(
    .RST_HOLD_CYCLES (16),
    .LOCK_TIMEOUT    (1024),
    .FAW_PERIOD      (64),
    .MISS_THRESHOLD  (4),
    .MAX_RETRIES     (7)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

`ifdef QECIPHY_RX_ALIGN_STATS_EN
  localparam logic [15:0] R1 = 16'd1;
  localparam logic [15:0] R2 = 16'd2;
`else
  localparam logic [15:0] R1 = 16'd0;
  localparam logic [15:0] R2 = 16'd0;
`endif

  typedef struct packed {
    logic        dp;
    logic        lock;
    logic        err;
    logic [3:0]  retry;
    logic [15:0] realign;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t val;
  } exp_t;

  exp_t exp_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.dp      = bus.dp_rst_n_o;
    o.lock    = bus.rx_locked_o;
    o.err     = bus.rx_error_o;
    o.retry   = bus.retry_count_o;
    o.realign = bus.realign_count_o;
    return o;
  endfunction

  task automatic expect_at(input int c, input logic dp, input logic lock, input logic err,
                           input logic [3:0] retry, input logic [15:0] realign);
    exp_t e;
    e.cyc         = c;
    e.val.dp      = dp;
    e.val.lock    = lock;
    e.val.err     = err;
    e.val.retry   = retry;
    e.val.realign = realign;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w == FAW_WORD) w = ~w;
    return w;
  endfunction

  // Monitor: every change of the observed outputs must match the next
  // queued expectation in both cycle stamp and value.
  initial begin
    obs_t prev;
    obs_t now;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      now = sample();
      if (now !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, now);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== now) begin
            bad++;
            $display("FAIL output_event got cyc=%0d val=%h want cyc=%0d val=%h",
                     cyc, now, e.cyc, e.val);
          end
        end
        prev = now;
      end
    end
  end

  initial begin
    int t;
    int s;
    bus.enable_i    = 1'b0;
    bus.aligned_i   = 1'b0;
    bus.tdata_64b_i = '0;
    #1 rst_n = 1'b0;
    tick(3);
    check("reset_outputs", 32'(sample()), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Bring-up: 16 cycles of datapath reset, lock one cycle after aligned.
    t = cyc;
    bus.enable_i = 1'b1;
    expect_at(t + 17, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
    tick(16);
    check("hold_dp_low", 32'(bus.dp_rst_n_o), 32'd0);
    tick(1);
    check("wait_dp_high", 32'(bus.dp_rst_n_o), 32'd1);
    tick(30);
    t = cyc;
    bus.aligned_i = 1'b1;
    expect_at(t + 1, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0);

    // FAW every 64 cycles for 10000 cycles; hits land on the last gap cycle.
    for (int i = 0; i < 10000; i++) begin
      bus.tdata_64b_i = (i % 64 == 0) ? FAW_WORD : rnd_word();
      tick(1);
    end
    bus.tdata_64b_i = '0;
    check("steady_locked", 32'(bus.rx_locked_o), 32'd1);
    check("steady_realign", 32'(bus.realign_count_o), 32'd0);

    // Last hit in cycle t+9985, then 4 empty periods -> RETRY at edge t+10242.
    expect_at(t + 10242, 1'b0, 1'b0, 1'b0, 4'd0, R1);
    expect_at(t + 10243, 1'b0, 1'b0, 1'b0, 4'd1, R1);
    expect_at(t + 10259, 1'b1, 1'b0, 1'b0, 4'd1, R1);
    tick(242);
    bus.aligned_i = 1'b0;
    tick(17);
    tick(5);
    t = cyc;
    bus.aligned_i = 1'b1;
    expect_at(t + 1, 1'b1, 1'b1, 1'b0, 4'd1, R1);
    tick(10);

    // aligned_i drops while locked, then enable_i drops during HOLD.
    t = cyc;
    bus.aligned_i = 1'b0;
    expect_at(t + 1, 1'b0, 1'b0, 1'b0, 4'd1, R2);
    expect_at(t + 2, 1'b0, 1'b0, 1'b0, 4'd2, R2);
    tick(7);
    bus.enable_i = 1'b0;
    expect_at(t + 8, 1'b0, 1'b0, 1'b0, 4'd0, R2);
    tick(1);
    check("idle_dp_low", 32'(bus.dp_rst_n_o), 32'd0);
    check("idle_retry_clr", 32'(bus.retry_count_o), 32'd0);
    tick(3);

    // enable_i drops during WAIT_ALIGN: dp_rst_n_o falls on the same edge.
    t = cyc;
    bus.enable_i = 1'b1;
    expect_at(t + 17, 1'b1, 1'b0, 1'b0, 4'd0, R2);
    tick(20);
    bus.enable_i = 1'b0;
    expect_at(t + 21, 1'b0, 1'b0, 1'b0, 4'd0, R2);
    tick(3);

    // aligned_i never asserts: 7 attempts of 16+1024+1 cycles, then FAILED.
    t = cyc;
    bus.enable_i = 1'b1;
    for (int a = 0; a < 7; a++) begin
      s = t + 1 + 1041 * a;
      expect_at(s + 16,   1'b1, 1'b0, 1'b0,       4'(a),     R2);
      expect_at(s + 1040, 1'b0, 1'b0, 1'b0,       4'(a),     R2);
      expect_at(s + 1041, 1'b0, 1'b0, (a == 6),   4'(a + 1), R2);
    end
    tick(7300);
    check("failed_error", 32'(bus.rx_error_o), 32'd1);
    check("failed_retry", 32'(bus.retry_count_o), 32'd7);
    t = cyc;
    bus.enable_i = 1'b0;
    expect_at(t + 1, 1'b0, 1'b0, 1'b0, 4'd0, R2);
    tick(2);
    check("exit_failed_retry", 32'(bus.retry_count_o), 32'd0);

    // Async reset while locked returns every output to its reset value.
    t = cyc;
    bus.enable_i  = 1'b1;
    bus.aligned_i = 1'b1;
    expect_at(t + 17, 1'b1, 1'b0, 1'b0, 4'd0, R2);
    expect_at(t + 18, 1'b1, 1'b1, 1'b0, 4'd0, R2);
    tick(25);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_at(cyc, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    #1;
    check("async_reset", 32'(sample()), 32'd0);
    bus.enable_i  = 1'b0;
    bus.aligned_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    check("events_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
